// File: rtl/imem_loader_pkg.sv
// rtl/imem_loader_pkg.sv - shared instruction types and loader state/error encodings
package imem_loader_pkg;

  typedef logic [3:0] opcode_t;
  typedef logic [3:0] bmask_t;
  typedef logic [7:0] addr_t;

  typedef struct packed {
    opcode_t opcode;
    bmask_t  bmask;
    addr_t   addr1;
    addr_t   addr2;
  } instr_t;

  typedef enum logic [3:0] {
    S_IDLE,
    S_LEN,
    S_B2,
    S_B1,
    S_B0,
    S_WR,
    S_CSUM,
    S_DONE,
    S_ERR
  } loader_state_t;

  typedef enum logic [1:0] {
    le_none,
    le_csum,
    le_opcode
  } loader_err_t;

  // Opcodes 4'b1011..4'b1110 are unassigned; the decoder uses the same rule.
  function automatic bit opcode_legal(opcode_t op);
    return !((op >= 4'b1011) && (op <= 4'b1110));
  endfunction

endpackage

// File: rtl/loader_xor_acc.sv
// rtl/loader_xor_acc.sv - 8-bit XOR accumulator with synchronous clear
module loader_xor_acc (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       i_clr,
  input  logic       i_en,
  input  logic [7:0] i_data,
  output logic [7:0] o_acc
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      o_acc <= 8'd0;
    end else if (i_clr) begin
      o_acc <= 8'd0;
    end else if (i_en) begin
      o_acc <= o_acc ^ i_data;
    end
  end

endmodule

// File: rtl/imem_loader.sv
// rtl/imem_loader.sv - length-prefixed, checksummed byte-stream loader into instruction memory
module imem_loader
  import imem_loader_pkg::*;
#(
  parameter bit                CHECK_OPCODE = 1'b1,
  parameter int                ADDR_W       = 8,
  parameter logic [ADDR_W-1:0] START_ADDR   = '0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [7:0]        s_data,
  input  logic              s_valid,
  output logic              s_ready,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [23:0]       imem_wdata,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [1:0]        err_code,
  output logic              core_hold
);

  loader_state_t r_state;
  loader_err_t   r_err_code;
  logic [15:0]   r_hi;
  logic [8:0]    r_cnt;

  logic          w_xfer;
  logic          w_idle;
  logic          w_acc_clr;
  logic          w_acc_en;
  logic [7:0]    w_acc;
  instr_t        w_full_word;

  assign w_xfer      = s_valid & s_ready;
  assign w_idle      = (r_state == S_IDLE) || (r_state == S_DONE) || (r_state == S_ERR);
  assign w_acc_clr   = start & w_idle;
  assign w_acc_en    = w_xfer & (r_state != S_CSUM);
  assign w_full_word = instr_t'({r_hi, s_data});
  assign err_code    = r_err_code;

  loader_xor_acc u_xor_acc (
    .clk    (clk),
    .rst_n  (rst_n),
    .i_clr  (w_acc_clr),
    .i_en   (w_acc_en),
    .i_data (s_data),
    .o_acc  (w_acc)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= S_IDLE;
      r_err_code <= le_none;
      r_hi       <= 16'd0;
      r_cnt      <= 9'd0;
      s_ready    <= 1'b0;
      imem_we    <= 1'b0;
      imem_addr  <= START_ADDR;
      imem_wdata <= 24'd0;
      busy       <= 1'b0;
      done       <= 1'b0;
      err        <= 1'b0;
      core_hold  <= 1'b1;
    end else begin
      imem_we <= 1'b0;
      unique case (r_state)
        S_IDLE, S_DONE, S_ERR: begin
          if (start) begin
            r_state    <= S_LEN;
            s_ready    <= 1'b1;
            busy       <= 1'b1;
            core_hold  <= 1'b1;
            done       <= 1'b0;
            err        <= 1'b0;
            r_err_code <= le_none;
            r_cnt      <= 9'd0;
            imem_addr  <= START_ADDR;
          end
        end
        S_LEN: begin
          if (w_xfer) begin
            r_cnt   <= (s_data == 8'd0) ? 9'd256 : {1'b0, s_data};
            r_state <= S_B2;
          end
        end
        S_B2: begin
          if (w_xfer) begin
            if (CHECK_OPCODE && !opcode_legal(opcode_t'(s_data[7:4]))) begin
              r_state    <= S_ERR;
              s_ready    <= 1'b0;
              busy       <= 1'b0;
              err        <= 1'b1;
              r_err_code <= le_opcode;
            end else begin
              r_hi[15:8] <= s_data;
              r_state    <= S_B1;
            end
          end
        end
        S_B1: begin
          if (w_xfer) begin
            r_hi[7:0] <= s_data;
            r_state   <= S_B0;
          end
        end
        S_B0: begin
          if (w_xfer) begin
            imem_we    <= 1'b1;
            imem_wdata <= w_full_word;
            s_ready    <= 1'b0;
            r_state    <= S_WR;
          end
        end
        // The write strobe is up during this cycle; advance address and count behind it.
        S_WR: begin
          imem_addr <= imem_addr + ADDR_W'(1);
          r_cnt     <= r_cnt - 9'd1;
          s_ready   <= 1'b1;
          r_state   <= (r_cnt == 9'd1) ? S_CSUM : S_B2;
        end
        S_CSUM: begin
          if (w_xfer) begin
            s_ready <= 1'b0;
            busy    <= 1'b0;
            if (s_data == w_acc) begin
              r_state   <= S_DONE;
              done      <= 1'b1;
              core_hold <= 1'b0;
            end else begin
              r_state    <= S_ERR;
              err        <= 1'b1;
              r_err_code <= le_csum;
            end
          end
        end
        default: begin
          r_state <= S_IDLE;
          s_ready <= 1'b0;
          busy    <= 1'b0;
        end
      endcase
    end
  end

endmodule
